fetch_redirect: RTL and testbench

Next-PC generation and prediction-tracking stage for the fetch front end. It owns the architectural fetch PC and drives it into the branch target buffer. It consumes the buffer's same-cycle hit/target result to steer the next fetch, and carries each prediction down the IF/ID and ID/EX pipeline. When the branch resolves in EX, it checks the prediction, and on a mispredict it redirects the PC, flushes the younger stages and issues a BTB update request.

---
 rtl/fetch_redirect_if.sv | 30 +++
 rtl/fetch_redirect.sv | 105 ++++++++++
 tb/tb_fetch_redirect.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_if.sv
// fetch_redirect_if
//   Bundles the fetch-stage signals exchanged between fetch_redirect and its
//   environment: decode stall, BTB lookup result, EX branch resolution,
//   fetch PC / flush outputs and the BTB update request.
//   master : the fetch_redirect side (drives pc, flush, upd_*)
//   slave  : the environment side (drives stall, btb_*, ex_*)
interface fetch_redirect_if;
    logic        stall;
    logic        btb_hit;
    logic [15:0] btb_target;
    logic        ex_is_br;
    logic        ex_taken;
    logic [15:0] ex_target;
    logic [15:0] pc;
    logic        flush;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;

    modport master (
        input  stall, btb_hit, btb_target, ex_is_br, ex_taken, ex_target,
        output pc, flush, upd_en, upd_pc, upd_target, upd_taken
    );

    modport slave (
        output stall, btb_hit, btb_target, ex_is_br, ex_taken, ex_target,
        input  pc, flush, upd_en, upd_pc, upd_target, upd_taken
    );
endinterface

// File: rtl/fetch_redirect.sv
// fetch_redirect
//   Owns the fetch PC, steers it from the same-cycle BTB result, carries each
//   prediction through IF/ID and ID/EX, and on EX resolution checks it:
//   a mispredict redirects the PC, flushes the two younger slots and the
//   resolved outcome is sent back to the BTB as a registered update request.
// Ports
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_redirect_if.master
//            in : stall, btb_hit, btb_target, ex_is_br, ex_taken, ex_target
//            out: pc, flush, upd_en, upd_pc, upd_target, upd_taken
module fetch_redirect (
    input  logic             clk,
    input  logic             rst_n,
    fetch_redirect_if.master bus
);
    logic [15:0] pc_reg, pc_next;

    // IF/ID tracking
    logic        v1_reg, pt1_reg;
    logic [15:0] pc1_reg, ptgt1_reg;
    // ID/EX tracking
    logic        v2_reg, pt2_reg;
    logic [15:0] pc2_reg, ptgt2_reg;

    logic        upd_en_reg, upd_taken_reg;
    logic [15:0] upd_pc_reg, upd_target_reg;

    logic        act_taken;
    logic        mp;
    logic        upd_fire;
    logic [15:0] correct_pc;

    // Only a valid EX slot may resolve; a bubble ignores the ex_* inputs.
    assign act_taken  = bus.ex_is_br & bus.ex_taken;
    // Direction mismatch covers both a missed taken branch and a BTB alias on
    // a non-branch (act_taken = 0 while pt2 = 1).
    assign mp         = v2_reg & ((act_taken != pt2_reg) |
                                  (act_taken & (bus.ex_target != ptgt2_reg)));
    // Every taken branch refreshes its entry; any predicted-taken slot that
    // was wrong about direction weakens it.
    assign upd_fire   = v2_reg & (pt2_reg | act_taken);
    assign correct_pc = act_taken ? bus.ex_target : pc2_reg + 16'd1;

    always_comb begin
        pc_next = pc_reg + 16'd1;
        if (mp)
            pc_next = correct_pc;
        else if (bus.stall)
            pc_next = pc_reg;
        else if (bus.btb_hit)
            pc_next = bus.btb_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= 16'h0000;
            v1_reg         <= 1'b0;
            pt1_reg        <= 1'b0;
            pc1_reg        <= 16'h0000;
            ptgt1_reg      <= 16'h0000;
            v2_reg         <= 1'b0;
            pt2_reg        <= 1'b0;
            pc2_reg        <= 16'h0000;
            ptgt2_reg      <= 16'h0000;
            upd_en_reg     <= 1'b0;
            upd_taken_reg  <= 1'b0;
            upd_pc_reg     <= 16'h0000;
            upd_target_reg <= 16'h0000;
        end else begin
            pc_reg     <= pc_next;
            upd_en_reg <= upd_fire;
            if (upd_fire) begin
                upd_pc_reg     <= pc2_reg;
                upd_target_reg <= bus.ex_target;
                upd_taken_reg  <= act_taken;
            end

            if (mp) begin
                // Redirect wins over stall: squash both younger slots.
                v1_reg <= 1'b0;
                v2_reg <= 1'b0;
            end else if (bus.stall) begin
                // IF/ID holds, EX receives a bubble.
                v2_reg <= 1'b0;
            end else begin
                v1_reg    <= 1'b1;
                pc1_reg   <= pc_reg;
                pt1_reg   <= bus.btb_hit;
                ptgt1_reg <= bus.btb_target;
                v2_reg    <= v1_reg;
                pc2_reg   <= pc1_reg;
                pt2_reg   <= pt1_reg;
                ptgt2_reg <= ptgt1_reg;
            end
        end
    end

    assign bus.pc         = pc_reg;
    assign bus.flush      = mp;
    assign bus.upd_en     = upd_en_reg;
    assign bus.upd_pc     = upd_pc_reg;
    assign bus.upd_target = upd_target_reg;
    assign bus.upd_taken  = upd_taken_reg;
endmodule

// File: tb/tb_fetch_redirect.sv
// tb_fetch_redirect
//   Drives directed and random fetch/resolve traffic into fetch_redirect.
//   A reference model (fetched-instruction queue + EX slot) predicts each
//   cycle's flush, next pc and update request; these are queued and a pair
//   of monitor processes compare them against the DUT outputs.
module tb_fetch_redirect;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_redirect_if bus ();

    fetch_redirect dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic        pt;
        logic [15:0] ptgt;
    } fetch_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        upd_en;
        logic [15:0] upd_pc;
        logic [15:0] upd_target;
        logic        upd_taken;
    } state_t;

    int checks   = 0;
    int failures = 0;

    logic   flush_q[$];
    state_t state_q[$];

    // Reference model: instructions fetched but not yet in EX, and the EX slot.
    logic [15:0] m_pc = 16'h0000;
    fetch_t      pend[$];
    fetch_t      ex_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        pend.delete();
        ex_q.delete();
    endtask

    // Applies one cycle of inputs, advances the model, queues expectations and
    // returns 3 time units after the next posedge.
    // mode 0: EX inputs agree with the prediction; mode 1: use br/tk/etgt.
    task automatic cycle(input logic st, input logic hit, input logic [15:0] tgt,
                         input int mode, input logic br, input logic tk,
                         input logic [15:0] etgt);
        fetch_t      e;
        logic        have, act, mpx, upd;
        logic [15:0] npc;
        state_t      s;
        have = (ex_q.size() != 0);
        e    = have ? ex_q[0] : '0;
        if (mode == 0) begin
            if (have && e.pt) begin
                br = 1'b1; tk = 1'b1; etgt = e.ptgt;
            end else begin
                br = 1'b0; tk = 1'b0;
            end
        end
        bus.stall      = st;
        bus.btb_hit    = hit;
        bus.btb_target = tgt;
        bus.ex_is_br   = br;
        bus.ex_taken   = tk;
        bus.ex_target  = etgt;

        act = br & tk;
        mpx = have && ((act != e.pt) || (act && (etgt != e.ptgt)));
        upd = have && (e.pt || act);
        if (mpx)
            npc = act ? etgt : e.pc + 16'd1;
        else if (st)
            npc = m_pc;
        else if (hit)
            npc = tgt;
        else
            npc = m_pc + 16'd1;

        if (mpx) begin
            pend.delete();
            ex_q.delete();
        end else if (st) begin
            ex_q.delete();
        end else begin
            ex_q.delete();
            if (pend.size() != 0) ex_q.push_back(pend.pop_front());
            pend.push_back('{pc: m_pc, pt: hit, ptgt: tgt});
        end
        m_pc = npc;

        s.pc         = npc;
        s.upd_en     = upd;
        s.upd_pc     = e.pc;
        s.upd_target = etgt;
        s.upd_taken  = act;
        flush_q.push_back(mpx);
        state_q.push_back(s);
        @(posedge clk);
        #3;
    endtask

    // Forces a mispredict in the current cycle, then asserts reset mid-cycle
    // while flush is high and checks the immediate clear.
    task automatic mp_reset();
        fetch_t e;
        logic   have, mpx;
        have = (ex_q.size() != 0);
        e    = have ? ex_q[0] : '0;
        bus.stall      = 1'b0;
        bus.btb_hit    = 1'b0;
        bus.btb_target = 16'h0000;
        bus.ex_is_br   = 1'b1;
        bus.ex_taken   = 1'b1;
        bus.ex_target  = 16'h0700;
        mpx = have && ((1'b1 != e.pt) || (16'h0700 != e.ptgt));
        flush_q.push_back(mpx);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pc", bus.pc, 16'h0000);
        chk("rst_mid_flush", {15'd0, bus.flush}, 16'h0000);
        chk("rst_mid_upd_en", {15'd0, bus.upd_en}, 16'h0000);
        chk("rst_mid_upd_pc", bus.upd_pc, 16'h0000);
        chk("rst_mid_upd_target", bus.upd_target, 16'h0000);
        chk("rst_mid_upd_taken", {15'd0, bus.upd_taken}, 16'h0000);
        flush_q.delete();
        state_q.delete();
        model_reset();
        bus.ex_is_br = 1'b0;
        bus.ex_taken = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // flush monitor: combinational output, sampled mid-cycle
    initial begin
        logic f;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && flush_q.size() != 0) begin
                f = flush_q.pop_front();
                chk("flush", {15'd0, bus.flush}, {15'd0, f});
            end
        end
    end

    // registered-output monitor: pc and update request after each edge
    initial begin
        state_t s;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && state_q.size() != 0) begin
                s = state_q.pop_front();
                chk("pc", bus.pc, s.pc);
                chk("upd_en", {15'd0, bus.upd_en}, {15'd0, s.upd_en});
                if (s.upd_en) begin
                    chk("upd_pc", bus.upd_pc, s.upd_pc);
                    chk("upd_target", bus.upd_target, s.upd_target);
                    chk("upd_taken", {15'd0, bus.upd_taken}, {15'd0, s.upd_taken});
                end
                $display("txn pc=%h upd_en=%0d upd_pc=%h upd_target=%h upd_taken=%0d",
                         bus.pc, bus.upd_en, bus.upd_pc, bus.upd_target, bus.upd_taken);
            end
        end
    end

    initial begin
        logic        st, hit, br, tk;
        logic [15:0] tgt, etgt;
        int          mode;
        bus.stall      = 1'b0;
        bus.btb_hit    = 1'b0;
        bus.btb_target = 16'h0000;
        bus.ex_is_br   = 1'b0;
        bus.ex_taken   = 1'b0;
        bus.ex_target  = 16'h0000;
        model_reset();

        #3;
        chk("rst_pc", bus.pc, 16'h0000);
        chk("rst_flush", {15'd0, bus.flush}, 16'h0000);
        chk("rst_upd_en", {15'd0, bus.upd_en}, 16'h0000);
        chk("rst_upd_pc", bus.upd_pc, 16'h0000);
        chk("rst_upd_target", bus.upd_target, 16'h0000);
        chk("rst_upd_taken", {15'd0, bus.upd_taken}, 16'h0000);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // sequential fetch from reset up to 0x0005
        repeat (5) cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        // predicted-taken branch at 0x0005 resolves as predicted
        cycle(1'b0, 1'b1, 16'h0040, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        // not-taken predicted at 0x0010, resolves taken to 0x0100
        cycle(1'b0, 1'b1, 16'h0010, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'h0100);
        // squashed slots: a taken branch on ex_* must be ignored
        cycle(1'b0, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'h0555);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        // predicted taken at 0x0020 -> 0x0080, resolves not taken
        cycle(1'b0, 1'b1, 16'h0020, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 16'h0080, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 1, 1'b1, 1'b0, 16'h0080);
        // alias variant at 0x0021: predicted taken on a non-branch
        cycle(1'b0, 1'b1, 16'h0080, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 16'h0033);
        // 3-cycle stall at 0x0030 with BTB hits that must not move pc
        cycle(1'b0, 1'b1, 16'h0030, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 16'h0099, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 16'h0099, 1, 1'b1, 1'b1, 16'h0123);
        cycle(1'b1, 1'b1, 16'h0099, 1, 1'b1, 1'b1, 16'h0123);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        // stall coincident with a mispredict: redirect still wins
        cycle(1'b0, 1'b1, 16'h0050, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'h0200);
        // wrap 0xFFFE -> 0xFFFF -> 0x0000 -> 0x0001
        cycle(1'b0, 1'b1, 16'hFFFE, 0, 1'b0, 1'b0, 16'h0000);
        repeat (3) cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        // reset while flush is high
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);
        mp_reset();
        repeat (4) cycle(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            st   = ($urandom_range(0, 4) == 0);
            hit  = ($urandom_range(0, 2) == 0);
            tgt  = ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'($urandom);
            mode = $urandom_range(0, 1);
            br   = 1'($urandom);
            tk   = 1'($urandom);
            if (ex_q.size() != 0 && $urandom_range(0, 1) == 0)
                etgt = ex_q[0].ptgt;
            else
                etgt = 16'($urandom);
            cycle(st, hit, tgt, mode, br, tk, etgt);
        end

        bus.stall = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("queues_drained", 16'(state_q.size() + flush_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
